// File: rtl/trace_pkg.sv
// Shared types for the CPU trace buffer: output FSM states, the FIFO entry
// layout and the byte1 packing.
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_PC  = 2'd1,
    SEND_RES = 2'd2
  } state_t;

  // res is stored zero-extended to 7 bits so byte1 packing is width-independent
  typedef struct packed {
    logic       drop;
    logic [7:0] pc;
    logic [6:0] res;
  } entry_t;

  function automatic logic [7:0] pack_byte1(entry_t e);
    return {e.drop, e.res};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Flop-based synchronous FIFO of trace entries with simultaneous push/pop.
// Also exposes the pc of the entry behind the head for gap-free streaming.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 wr_data,
  output entry_t                 head,
  output logic [7:0]             next_pc,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  assign head    = mem[rd_ptr];
  assign next_pc = mem[rd_ptr + AW'(1)].pc;

endmodule

// File: rtl/cpu_trace_buffer.sv
// Records (PC, ALU result) on every PC change and streams each entry as two
// bytes over a valid/ready port without ever stalling the CPU.
//
// state    | meaning
// IDLE     | FIFO empty, out_valid low
// SEND_PC  | offering byte0 (head pc)
// SEND_RES | offering byte1 ({drop, res}); handshake pops the head
module cpu_trace_buffer
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PC_W  = 8,
  parameter int RES_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cap_en,
  input  logic [PC_W-1:0]        pc_in,
  input  logic [RES_W-1:0]       res_in,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_t     state;
  logic       have_last;
  logic       drop_pend;
  logic [7:0] last_pc;
  logic       cap_want;
  logic       pop;
  logic       wr_ok;
  logic       push;
  entry_t     wr_entry;
  entry_t     head;
  logic [7:0] next_pc;

  assign cap_want = cap_en && (!have_last || (8'(pc_in) != last_pc));
  assign pop      = (state == SEND_RES) && out_ready;
  // a full FIFO still takes a write on the edge that pops its head
  assign wr_ok    = (count < CW'(DEPTH)) || pop;
  assign push     = cap_want && wr_ok;

  always_comb begin
    wr_entry      = '0;
    wr_entry.drop = drop_pend;
    wr_entry.pc   = 8'(pc_in);
    wr_entry.res  = 7'(res_in);
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push    (push),
    .pop     (pop),
    .wr_data (wr_entry),
    .head    (head),
    .next_pc (next_pc),
    .count   (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      have_last <= 1'b0;
      last_pc   <= '0;
      drop_pend <= 1'b0;
      overflow  <= 1'b0;
    end else if (push) begin
      have_last <= 1'b1;
      last_pc   <= wr_entry.pc;
      drop_pend <= 1'b0;
    end else if (cap_want) begin
      drop_pend <= 1'b1;
      overflow  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            state     <= SEND_PC;
            out_valid <= 1'b1;
            out_data  <= head.pc;
          end
        end
        SEND_PC: begin
          if (out_ready) begin
            state    <= SEND_RES;
            out_data <= pack_byte1(head);
          end
        end
        SEND_RES: begin
          if (out_ready) begin
            // next head is the second entry, or the one written this very edge
            if ((count > CW'(1)) || push) begin
              state    <= SEND_PC;
              out_data <= (count > CW'(1)) ? next_pc : wr_entry.pc;
            end else begin
              state     <= IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed bench for cpu_trace_buffer: ordering, dedup, overflow/drop flag,
// full-with-pop write, stall stability and mid-transfer reset.
module tb_cpu_trace_buffer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cap_en = 1'b0;
  logic [7:0] pc_in = '0;
  logic [3:0] res_in = '0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] count;
  logic       overflow;

  int tests = 0;
  int fails = 0;
  logic [7:0] got[$];

  cpu_trace_buffer #(.DEPTH(8), .PC_W(8), .RES_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cap_en    (cap_en),
    .pc_in     (pc_in),
    .res_in    (res_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // records each byte handshaken; caller clears got beforehand
  task automatic collect(input int n, input int max_cyc);
    int c = 0;
    while (got.size() < n && c < max_cyc) begin
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
      c++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cap_en = 1'b0; out_ready = 1'b0; pc_in = '0; res_in = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", out_data); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b[6] = '{8'h00, 8'h03, 8'h01, 8'h05, 8'h02, 8'h07};
    got.delete();
    out_ready = 1'b1; cap_en = 1'b1;
    pc_in = 8'h00; res_in = 4'd3;
    tick();
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL basic_count_e got %0d exp 1", count); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_latency_e got %b exp 0", out_valid); end
    pc_in = 8'h01; res_in = 4'd5;
    tick();
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency_e1 got %b exp 1", out_valid); end
    if (out_valid && out_ready) got.push_back(out_data);
    pc_in = 8'h02; res_in = 4'd7;
    tick();
    collect(6, 40);
    tests++; if (got.size() != 6) begin fails++; $display("FAIL basic_nbytes got %0d exp 6", got.size()); end
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        tests++;
        if (got[i] !== exp_b[i]) begin fails++; $display("FAIL basic_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
      end
    end
    tests++; if (out_valid !== 1'b0 || count !== 4'd0) begin fails++; $display("FAIL basic_drained got valid=%b count=%0d exp 0/0", out_valid, count); end
  endtask

  task automatic test_hold();
    int peak = 0;
    out_ready = 1'b0; cap_en = 1'b1; pc_in = 8'h05; res_in = 4'd1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int'(count) > peak) peak = int'(count);
    end
    tests++; if (peak != 1) begin fails++; $display("FAIL hold_peak got %0d exp 1", peak); end
    got.delete();
    out_ready = 1'b1;
    collect(2, 20);
    tests++; if (got.size() != 2) begin fails++; $display("FAIL hold_nbytes got %0d exp 2", got.size()); end
    else begin
      tests++; if (got[0] !== 8'h05 || got[1] !== 8'h01) begin fails++; $display("FAIL hold_bytes got %h %h exp 05 01", got[0], got[1]); end
    end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL hold_count got %0d exp 0", count); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0; cap_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pc_in = 8'h10 + 8'(i); res_in = 4'(i);
      tick();
    end
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL ovf_count got %0d exp 8", count); end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_flag got %b exp 1", overflow); end
    cap_en = 1'b0; out_ready = 1'b1;
    got.delete();
    collect(16, 100);
    tests++; if (got.size() != 16) begin fails++; $display("FAIL ovf_nbytes got %0d exp 16", got.size()); end
    for (int i = 0; i < 8; i++) begin
      if (2*i+1 < got.size()) begin
        tests++;
        if (got[2*i] !== 8'h10 + 8'(i) || got[2*i+1] !== 8'(i)) begin
          fails++; $display("FAIL ovf_entry%0d got %h %h exp %h %h", i, got[2*i], got[2*i+1], 8'h10 + 8'(i), 8'(i));
        end
      end
    end
    cap_en = 1'b1; pc_in = 8'h30; res_in = 4'd9;
    got.delete();
    collect(2, 20);
    tests++; if (got.size() != 2) begin fails++; $display("FAIL ovf_drop_nbytes got %0d exp 2", got.size()); end
    else begin
      tests++; if (got[0] !== 8'h30 || got[1] !== 8'h89) begin fails++; $display("FAIL ovf_drop_entry got %h %h exp 30 89", got[0], got[1]); end
    end
    tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
  endtask

  task automatic test_full_pop();
    reset = 1'b0; #2 reset = 1'b1;
    out_ready = 1'b0; cap_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pc_in = 8'h40 + 8'(i); res_in = 4'(i);
      tick();
    end
    tests++; if (count !== 4'd8 || overflow !== 1'b0) begin fails++; $display("FAIL full_fill got count=%0d ovf=%b exp 8/0", count, overflow); end
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h40) begin fails++; $display("FAIL full_head got valid=%b data=%h exp 1/40", out_valid, out_data); end
    cap_en = 1'b0; out_ready = 1'b1;
    tick();
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL full_byte1 got %h exp 00", out_data); end
    cap_en = 1'b1; pc_in = 8'h48; res_in = 4'd8;
    tick();
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL full_pushpop_count got %0d exp 8", count); end
    tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL full_pushpop_ovf got %b exp 0", overflow); end
    tests++; if (out_data !== 8'h41) begin fails++; $display("FAIL full_next_pc got %h exp 41", out_data); end
    cap_en = 1'b0;
    got.delete();
    collect(16, 100);
    tests++; if (got.size() != 16) begin fails++; $display("FAIL full_nbytes got %0d exp 16", got.size()); end
    for (int k = 0; k < 8; k++) begin
      if (2*k+1 < got.size()) begin
        tests++;
        if (got[2*k] !== 8'h41 + 8'(k) || got[2*k+1] !== 8'(k+1)) begin
          fails++; $display("FAIL full_entry%0d got %h %h exp %h %h", k, got[2*k], got[2*k+1], 8'h41 + 8'(k), 8'(k+1));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic       pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [7:0] exp_b[4] = '{8'h50, 8'h0A, 8'h51, 8'h0B};
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    int         c = 0;
    out_ready = 1'b0; cap_en = 1'b1;
    pc_in = 8'h50; res_in = 4'hA; tick();
    pc_in = 8'h51; res_in = 4'hB; tick();
    cap_en = 1'b0;
    got.delete();
    while (got.size() < 4 && c < 40) begin
      out_ready = pat[c % 4];
      #0;
      if (prev_stall) begin
        tests++;
        if (out_data !== prev_data) begin fails++; $display("FAIL stall_stable got %h exp %h", out_data, prev_data); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      tick();
      c++;
    end
    tests++; if (got.size() != 4) begin fails++; $display("FAIL stall_nbytes got %0d exp 4", got.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) begin
        tests++;
        if (got[i] !== exp_b[i]) begin fails++; $display("FAIL stall_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
      end
    end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL stall_count got %0d exp 0", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; cap_en = 1'b1;
    pc_in = 8'h60; res_in = 4'd3; tick();
    pc_in = 8'h61; res_in = 4'd4; tick();
    cap_en = 1'b0; out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin fails++; $display("FAIL mid_in_res got valid=%b data=%h exp 1/03", out_valid, out_data); end
    reset = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b exp 0", out_valid); end
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL mid_count got %0d exp 0", count); end
    #2 reset = 1'b1;
    cap_en = 1'b1; pc_in = 8'h61; res_in = 4'd5;
    tick();
    tests++; if (count !== 4'd1) begin fails++; $display("FAIL mid_recapture got %0d exp 1", count); end
    got.delete();
    collect(2, 20);
    tests++; if (got.size() != 2) begin fails++; $display("FAIL mid_nbytes got %0d exp 2", got.size()); end
    else begin
      tests++; if (got[0] !== 8'h61 || got[1] !== 8'h05) begin fails++; $display("FAIL mid_bytes got %h %h exp 61 05", got[0], got[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_overflow();
    test_full_pop();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
